// File: rtl/serial_feeder.sv
// Parallel-to-serial front end: buffers one WIDTH-bit word and shifts words out
// one bit per clock, back-to-back, with word-boundary pulses for the detector.
module serial_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             word_start,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic             hold_full, hold_full_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             ready_q;
    logic             accept;

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
        else           return {1'b0, v[WIDTH-1:1]};
    endfunction

    // ready_q mirrors !hold_full except while in reset, so it also gates accepts
    assign accept = in_valid && ready_q && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            sh        <= '0;
            cnt       <= '0;
            ready_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
            sh        <= sh_nxt;
            cnt       <= cnt_nxt;
            ready_q   <= !hold_full_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        sh_nxt        = sh;
        cnt_nxt       = cnt;

        if (accept) begin
            hold_nxt      = in_data;
            hold_full_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (hold_full) begin
                    sh_nxt        = hold;
                    hold_full_nxt = 1'b0;
                    cnt_nxt       = '0;
                    state_nxt     = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    cnt_nxt = '0;
                    if (hold_full) begin
                        // Reload on the last bit so the next word follows with no gap
                        sh_nxt        = hold;
                        hold_full_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    sh_nxt  = advance(sh);
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (abort) begin
            hold_full_nxt = 1'b0;
            state_nxt     = IDLE;
            cnt_nxt       = '0;
        end
    end

    assign in_ready   = ready_q;
    assign ser_valid  = (state == SHIFT);
    assign ser_data   = (state == SHIFT) ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT;
    assign word_start = (state == SHIFT) && (cnt == '0);
    assign word_done  = (state == SHIFT) && (cnt == LAST);
    assign busy       = hold_full || (state == SHIFT);

endmodule
